gbt_link_ctrl: RTL and testbench



---
 rtl/gbt_link_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_gbt_link_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gbt_link_ctrl.sv
// GBT bank bring-up and supervision sequencer (MGMT frame clock domain).
// Sequences general reset, TX lock, RX reset, RX lock and a stability window,
// then supervises the link and re-sequences on timeout or loss.
module gbt_link_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4000000,
  parameter int STABLE_CYCLES = 40000
) (
  input  logic        clk_ik,
  input  logic        rstn_ir,
  input  logic        enable_i,
  input  logic        tx_ready_i,
  input  logic        rx_ready_i,
  input  logic        los_i,
  input  logic        clr_cnt_i,
  output logic        gen_rst_o,
  output logic        rx_rst_o,
  output logic        sfp_txdisable_o,
  output logic        flag_clr_o,
  output logic        link_up_o,
  output logic [2:0]  state_o,
  output logic [7:0]  retry_cnt_o,
  output logic [15:0] loss_cnt_o
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TW    = $clog2(MAX_P) + 1;

  localparam logic [TW-1:0] RST_T    = TW'(RST_CYCLES);
  localparam logic [TW-1:0] LOCK_T   = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] STABLE_T = TW'(STABLE_CYCLES);
  localparam logic [TW-1:0] ONE_T    = TW'(1);

  typedef enum logic [2:0] {
    S_DISABLED = 3'd0,
    S_GEN_RST  = 3'd1,
    S_WAIT_TX  = 3'd2,
    S_RX_RST   = 3'd3,
    S_WAIT_RX  = 3'd4,
    S_STABLE   = 3'd5,
    S_UP       = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      retry_q, retry_d;
  logic [15:0]     loss_q, loss_d;
  logic            retry_inc, loss_inc;
  logic            gen_rst_q, gen_rst_d;
  logic            rx_rst_q, rx_rst_d;
  logic            txdis_q, txdis_d;
  logic            flag_clr_q, flag_clr_d;
  logic            link_up_q, link_up_d;
  logic            rx_good;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rx_good = rx_ready_i & ~los_i;

  // Next-state, timer, counter-increment and registered-output decode
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (!enable_i) begin
      state_d = S_DISABLED;
    end else begin
      case (state_q)
        S_DISABLED: begin
          state_d = S_GEN_RST;
          timer_d = RST_T;
        end
        S_GEN_RST: begin
          if (timer_q <= ONE_T) begin
            state_d = S_WAIT_TX;
            timer_d = LOCK_T;
          end else begin
            timer_d = timer_q - ONE_T;
          end
        end
        S_WAIT_TX: begin
          if (tx_ready_i) begin
            state_d = S_RX_RST;
            timer_d = RST_T;
          end else if (timer_q <= ONE_T) begin
            state_d   = S_GEN_RST;
            timer_d   = RST_T;
            retry_inc = 1'b1;
          end else begin
            timer_d = timer_q - ONE_T;
          end
        end
        S_RX_RST: begin
          if (!tx_ready_i) begin
            state_d = S_GEN_RST;
            timer_d = RST_T;
          end else if (timer_q <= ONE_T) begin
            state_d = S_WAIT_RX;
            timer_d = LOCK_T;
          end else begin
            timer_d = timer_q - ONE_T;
          end
        end
        S_WAIT_RX: begin
          if (!tx_ready_i) begin
            state_d = S_GEN_RST;
            timer_d = RST_T;
          end else if (rx_good) begin
            state_d = S_STABLE;
            timer_d = STABLE_T;
          end else if (los_i) begin
            // No fibre: wait indefinitely without counting a retry
            timer_d = LOCK_T;
          end else if (timer_q <= ONE_T) begin
            state_d   = S_GEN_RST;
            timer_d   = RST_T;
            retry_inc = 1'b1;
          end else begin
            timer_d = timer_q - ONE_T;
          end
        end
        S_STABLE: begin
          if (!tx_ready_i) begin
            state_d = S_GEN_RST;
            timer_d = RST_T;
          end else if (!rx_good) begin
            state_d = S_RX_RST;
            timer_d = RST_T;
          end else if (timer_q <= ONE_T) begin
            state_d = S_UP;
          end else begin
            timer_d = timer_q - ONE_T;
          end
        end
        S_UP: begin
          if (!tx_ready_i) begin
            state_d  = S_GEN_RST;
            timer_d  = RST_T;
            loss_inc = 1'b1;
          end else if (!rx_good) begin
            state_d  = S_RX_RST;
            timer_d  = RST_T;
            loss_inc = 1'b1;
          end
        end
        default: state_d = S_DISABLED;
      endcase
    end

    gen_rst_d  = (state_d == S_DISABLED) || (state_d == S_GEN_RST);
    rx_rst_d   = (state_d == S_RX_RST);
    txdis_d    = (state_d == S_DISABLED);
    link_up_d  = (state_d == S_UP);
    flag_clr_d = (state_d == S_UP) && (state_q != S_UP);

    // Clear wins over a simultaneous increment
    if (clr_cnt_i) begin
      retry_d = 8'd0;
      loss_d  = 16'd0;
    end else begin
      retry_d = retry_inc ? sat_inc8(retry_q) : retry_q;
      loss_d  = loss_inc ? sat_inc16(loss_q) : loss_q;
    end
  end

  // State, timer, counters and outputs register with synchronous active-low reset
  always_ff @(posedge clk_ik) begin
    if (!rstn_ir) begin
      state_q    <= S_DISABLED;
      timer_q    <= '0;
      retry_q    <= 8'd0;
      loss_q     <= 16'd0;
      gen_rst_q  <= 1'b1;
      rx_rst_q   <= 1'b0;
      txdis_q    <= 1'b1;
      flag_clr_q <= 1'b0;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      gen_rst_q  <= gen_rst_d;
      rx_rst_q   <= rx_rst_d;
      txdis_q    <= txdis_d;
      flag_clr_q <= flag_clr_d;
      link_up_q  <= link_up_d;
    end
  end

  assign gen_rst_o       = gen_rst_q;
  assign rx_rst_o        = rx_rst_q;
  assign sfp_txdisable_o = txdis_q;
  assign flag_clr_o      = flag_clr_q;
  assign link_up_o       = link_up_q;
  assign state_o         = state_q;
  assign retry_cnt_o     = retry_q;
  assign loss_cnt_o      = loss_q;

endmodule

// File: tb/tb_gbt_link_ctrl.sv
// Directed testbench for gbt_link_ctrl with small timing parameters.
module tb_gbt_link_ctrl;

  logic        clk_ik = 1'b0;
  logic        rstn_ir;
  logic        enable_i;
  logic        tx_ready_i;
  logic        rx_ready_i;
  logic        los_i;
  logic        clr_cnt_i;
  logic        gen_rst_o;
  logic        rx_rst_o;
  logic        sfp_txdisable_o;
  logic        flag_clr_o;
  logic        link_up_o;
  logic [2:0]  state_o;
  logic [7:0]  retry_cnt_o;
  logic [15:0] loss_cnt_o;

  int checks = 0;
  int errors = 0;

  gbt_link_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (50),
    .STABLE_CYCLES(10)
  ) dut (
    .clk_ik         (clk_ik),
    .rstn_ir        (rstn_ir),
    .enable_i       (enable_i),
    .tx_ready_i     (tx_ready_i),
    .rx_ready_i     (rx_ready_i),
    .los_i          (los_i),
    .clr_cnt_i      (clr_cnt_i),
    .gen_rst_o      (gen_rst_o),
    .rx_rst_o       (rx_rst_o),
    .sfp_txdisable_o(sfp_txdisable_o),
    .flag_clr_o     (flag_clr_o),
    .link_up_o      (link_up_o),
    .state_o        (state_o),
    .retry_cnt_o    (retry_cnt_o),
    .loss_cnt_o     (loss_cnt_o)
  );

  always #10 clk_ik = ~clk_ik;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_ik);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rstn_ir    = 1'b0;
    enable_i   = 1'b0;
    tx_ready_i = 1'b1;
    rx_ready_i = 1'b1;
    los_i      = 1'b0;
    clr_cnt_i  = 1'b0;
    step(3);

    // Reset values
    chk("rst_state",   int'(state_o), 0);
    chk("rst_gen_rst", int'(gen_rst_o), 1);
    chk("rst_rx_rst",  int'(rx_rst_o), 0);
    chk("rst_txdis",   int'(sfp_txdisable_o), 1);
    chk("rst_flag",    int'(flag_clr_o), 0);
    chk("rst_link",    int'(link_up_o), 0);
    chk("rst_retry",   int'(retry_cnt_o), 0);
    chk("rst_loss",    int'(loss_cnt_o), 0);

    rstn_ir = 1'b1;
    step(1);
    chk("idle_state", int'(state_o), 0);
    chk("idle_txdis", int'(sfp_txdisable_o), 1);

    // Best-case bring-up: UP on clock 21 after enable
    enable_i = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step(1);
      chk($sformatf("bu_gen_rst_%0d", k), int'(gen_rst_o), int'(k <= 4));
      chk($sformatf("bu_rx_rst_%0d", k), int'(rx_rst_o), int'(k >= 6 && k <= 9));
      chk($sformatf("bu_link_%0d", k), int'(link_up_o), int'(k >= 21));
      chk($sformatf("bu_flag_%0d", k), int'(flag_clr_o), int'(k == 21));
      chk($sformatf("bu_txdis_%0d", k), int'(sfp_txdisable_o), 0);
    end
    chk("bu_state_wait_tx_done", int'(state_o), 6);
    chk("bu_retry", int'(retry_cnt_o), 0);
    chk("bu_loss",  int'(loss_cnt_o), 0);

    // One-clock rx_ready drop in UP
    rx_ready_i = 1'b0;
    step(1);
    rx_ready_i = 1'b1;
    chk("loss1_link",  int'(link_up_o), 0);
    chk("loss1_cnt",   int'(loss_cnt_o), 1);
    chk("loss1_state", int'(state_o), 3);
    step(14);
    chk("loss1_stable", int'(state_o), 5);
    chk("loss1_link15", int'(link_up_o), 0);
    step(1);
    chk("loss1_up",   int'(state_o), 6);
    chk("loss1_relink", int'(link_up_o), 1);
    chk("loss1_flag", int'(flag_clr_o), 1);

    // Clear coincident with a loss event
    rx_ready_i = 1'b0;
    clr_cnt_i  = 1'b1;
    step(1);
    rx_ready_i = 1'b0;
    clr_cnt_i  = 1'b0;
    rx_ready_i = 1'b1;
    chk("clr_loss",  int'(loss_cnt_o), 0);
    chk("clr_state", int'(state_o), 3);
    step(15);
    chk("clr_relink", int'(link_up_o), 1);

    // Glitch at STABLE clock 9 of 10: loss event first puts us in RX_RST
    rx_ready_i = 1'b0;
    step(1);
    rx_ready_i = 1'b1;
    chk("gl_loss", int'(loss_cnt_o), 1);
    step(13);
    chk("gl_stable9", int'(state_o), 5);
    rx_ready_i = 1'b0;
    step(1);
    rx_ready_i = 1'b1;
    chk("gl_state", int'(state_o), 3);
    chk("gl_loss_same", int'(loss_cnt_o), 1);
    chk("gl_flag", int'(flag_clr_o), 0);
    chk("gl_link", int'(link_up_o), 0);
    step(14);
    chk("gl_flag_pre", int'(flag_clr_o), 0);
    chk("gl_pre_up", int'(state_o), 5);
    step(1);
    chk("gl_up", int'(state_o), 6);
    chk("gl_flag_up", int'(flag_clr_o), 1);

    // LOS held in WAIT_RX: no retries
    los_i = 1'b1;
    step(1);
    chk("los_state", int'(state_o), 3);
    chk("los_loss", int'(loss_cnt_o), 2);
    step(4);
    chk("los_wait_rx", int'(state_o), 4);
    step(500);
    chk("los_hold_state", int'(state_o), 4);
    chk("los_hold_retry", int'(retry_cnt_o), 0);
    los_i = 1'b0;
    step(10);
    chk("los_rel_stable", int'(state_o), 5);
    step(1);
    chk("los_rel_up", int'(state_o), 6);
    chk("los_rel_link", int'(link_up_o), 1);

    // Disable while in WAIT_RX keeps counters
    los_i = 1'b1;
    step(5);
    chk("dis_pre", int'(state_o), 4);
    enable_i = 1'b0;
    step(1);
    los_i = 1'b0;
    chk("dis_state", int'(state_o), 0);
    chk("dis_gen_rst", int'(gen_rst_o), 1);
    chk("dis_txdis", int'(sfp_txdisable_o), 1);
    chk("dis_loss_kept", int'(loss_cnt_o), 3);

    // WAIT_TX timeout and retry saturation
    tx_ready_i = 1'b0;
    enable_i   = 1'b1;
    step(54);
    chk("to_wait_tx", int'(state_o), 2);
    chk("to_retry0", int'(retry_cnt_o), 0);
    step(1);
    chk("to_gen_rst", int'(state_o), 1);
    chk("to_retry1", int'(retry_cnt_o), 1);
    step(54);
    chk("to_retry2", int'(retry_cnt_o), 2);
    step(298 * 54);
    chk("to_sat", int'(retry_cnt_o), 255);
    chk("to_loss_kept", int'(loss_cnt_o), 3);

    // Counter clear
    clr_cnt_i = 1'b1;
    step(1);
    clr_cnt_i = 1'b0;
    chk("clr_retry", int'(retry_cnt_o), 0);
    chk("clr_loss2", int'(loss_cnt_o), 0);

    // Mid-operation reset
    step(3);
    rstn_ir = 1'b0;
    step(1);
    chk("mid_rst_state", int'(state_o), 0);
    chk("mid_rst_gen", int'(gen_rst_o), 1);
    chk("mid_rst_txdis", int'(sfp_txdisable_o), 1);
    rstn_ir = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
